// File: rtl/trivium_keystream_gen_if.sv
// Seed-in / keystream-out bus of the Trivium keystream generator.
// master = the block driving seed bytes and consuming keystream; slave = the generator.
interface trivium_keystream_gen_if;
   logic       clear;
   logic       seed_valid;
   logic [7:0] seed_byte;
   logic       ks_ready;
   logic [7:0] ks_byte;
   logic       ks_valid;
   logic       busy;
   logic       seeded;
   logic       seed_err;

   modport master (
      output clear, seed_valid, seed_byte, ks_ready,
      input  ks_byte, ks_valid, busy, seeded, seed_err
   );

   modport slave (
      input  clear, seed_valid, seed_byte, ks_ready,
      output ks_byte, ks_valid, busy, seeded, seed_err
   );
endinterface

// File: rtl/trivium_keystream_gen.sv
// Trivium keystream generator: byte-wise key/IV load, warm-up, one keystream bit per clock.
// Define TRIVIUM_SEED_EXPAND_EN to seed from a single byte (key = B x10, IV = (B^A5) x10).
module trivium_keystream_gen #(
   parameter int WARMUP_CYCLES = 1152,
   parameter int KEY_BYTES     = 10,
   parameter int IV_BYTES      = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   trivium_keystream_gen_if.slave bus
);
   localparam int SCW     = $clog2(WARMUP_CYCLES + 1);
   localparam int BCW     = $clog2(KEY_BYTES + IV_BYTES);
   localparam int IV_BASE = 94;
   localparam logic [SCW-1:0] STEP_LAST = SCW'(WARMUP_CYCLES - 1);
   localparam logic [BCW-1:0] BYTE_LAST = BCW'(KEY_BYTES + IV_BYTES - 1);

   typedef enum logic [2:0] {IDLE, LOAD, WARMUP, GEN, HOLD} fsm_t;

   fsm_t           fsm_reg;
   logic [288:1]   state_reg;
   logic [288:1]   step_next;
   logic [288:1]   seed_next;
   logic [SCW-1:0] step_cnt_reg;
   logic [BCW-1:0] byte_cnt_reg;
   logic [2:0]     bit_cnt_reg;
   logic [7:0]     ks_byte_reg;
   logic           ks_valid_reg;
   logic           busy_reg;
   logic           seeded_reg;
   logic           seed_err_reg;
   logic           t1;
   logic           t2;
   logic           t3;
   logic           z;

   // Bit n of state_reg is Trivium register bit s(n).
   always_comb begin
      t1 = state_reg[66]  ^ state_reg[93];
      t2 = state_reg[162] ^ state_reg[177];
      t3 = state_reg[243] ^ state_reg[288];
      z  = t1 ^ t2 ^ t3;
      step_next = {
         state_reg[287:178], t2 ^ (state_reg[175] & state_reg[176]) ^ state_reg[264],
         state_reg[176:94],  t1 ^ (state_reg[91]  & state_reg[92])  ^ state_reg[171],
         state_reg[92:1],    t3 ^ (state_reg[286] & state_reg[287]) ^ state_reg[69]
      };
   end

   genvar gi;
`ifdef TRIVIUM_SEED_EXPAND_EN
   generate
      for (gi = 0; gi < KEY_BYTES; gi++) begin : g_key
         assign seed_next[8*gi+8 : 8*gi+1] = bus.seed_byte;
      end
      for (gi = 0; gi < IV_BYTES; gi++) begin : g_iv
         assign seed_next[IV_BASE+8*gi+7 : IV_BASE+8*gi] = bus.seed_byte ^ 8'hA5;
      end
   endgenerate
`else
   // Each slot takes the incoming byte only when byte_cnt points at it.
   generate
      for (gi = 0; gi < KEY_BYTES; gi++) begin : g_key
         assign seed_next[8*gi+8 : 8*gi+1] = (byte_cnt_reg == BCW'(gi)) ?
            bus.seed_byte : state_reg[8*gi+8 : 8*gi+1];
      end
      for (gi = 0; gi < IV_BYTES; gi++) begin : g_iv
         assign seed_next[IV_BASE+8*gi+7 : IV_BASE+8*gi] = (byte_cnt_reg == BCW'(KEY_BYTES + gi)) ?
            bus.seed_byte : state_reg[IV_BASE+8*gi+7 : IV_BASE+8*gi];
      end
   endgenerate
`endif

   assign seed_next[IV_BASE-1 : 8*KEY_BYTES+1]  = '0;
   assign seed_next[177 : IV_BASE+8*IV_BYTES]   = '0;
   assign seed_next[285:178]                    = '0;
   assign seed_next[288:286]                    = 3'b111;

   always_ff @(posedge clk) begin
      if (!rst_n || bus.clear) begin
         fsm_reg      <= IDLE;
         state_reg    <= '0;
         step_cnt_reg <= '0;
         byte_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         ks_byte_reg  <= '0;
         ks_valid_reg <= 1'b0;
         busy_reg     <= 1'b0;
         seeded_reg   <= 1'b0;
         seed_err_reg <= 1'b0;
      end else begin
         seed_err_reg <= 1'b0;
         unique case (fsm_reg)
            IDLE: begin
               if (bus.seed_valid) begin
                  state_reg <= seed_next;
                  busy_reg  <= 1'b1;
`ifdef TRIVIUM_SEED_EXPAND_EN
                  step_cnt_reg <= '0;
                  fsm_reg      <= WARMUP;
`else
                  byte_cnt_reg <= BCW'(1);
                  fsm_reg      <= LOAD;
`endif
               end
            end
            LOAD: begin
               if (bus.seed_valid) begin
                  state_reg <= seed_next;
                  if (byte_cnt_reg == BYTE_LAST) begin
                     byte_cnt_reg <= '0;
                     step_cnt_reg <= '0;
                     fsm_reg      <= WARMUP;
                  end else begin
                     byte_cnt_reg <= byte_cnt_reg + 1'b1;
                  end
               end
            end
            WARMUP: begin
               state_reg    <= step_next;
               seed_err_reg <= bus.seed_valid;
               step_cnt_reg <= step_cnt_reg + 1'b1;
               if (step_cnt_reg == STEP_LAST) begin
                  bit_cnt_reg <= '0;
                  seeded_reg  <= 1'b1;
                  fsm_reg     <= GEN;
               end
            end
            GEN: begin
               state_reg                <= step_next;
               seed_err_reg             <= bus.seed_valid;
               ks_byte_reg[bit_cnt_reg] <= z;
               bit_cnt_reg              <= bit_cnt_reg + 1'b1;
               if (bit_cnt_reg == 3'd7) begin
                  ks_valid_reg <= 1'b1;
                  busy_reg     <= 1'b0;
                  fsm_reg      <= HOLD;
               end
            end
            HOLD: begin
               seed_err_reg <= bus.seed_valid;
               if (ks_valid_reg && bus.ks_ready) begin
                  ks_valid_reg <= 1'b0;
                  busy_reg     <= 1'b1;
                  fsm_reg      <= GEN;
               end
            end
            default: fsm_reg <= IDLE;
         endcase
      end
   end

   assign bus.ks_byte  = ks_byte_reg;
   assign bus.ks_valid = ks_valid_reg;
   assign bus.busy     = busy_reg;
   assign bus.seeded   = seeded_reg;
   assign bus.seed_err = seed_err_reg;

endmodule

// File: tb/tb_trivium_keystream_gen.sv
// Randomized self-checking bench for trivium_keystream_gen against a bit-array Trivium model.
module tb_trivium_keystream_gen;
   localparam int WARMUP = 1152;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   trivium_keystream_gen_if bus ();

   trivium_keystream_gen #(
      .WARMUP_CYCLES(WARMUP),
      .KEY_BYTES    (10),
      .IV_BYTES     (10)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] key_arr [10];
   logic [7:0] iv_arr  [10];
   bit         s [1:288];
   logic [7:0] exp_q  [$];
   logic [7:0] got_q  [$];
   logic [7:0] base_q [$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One Trivium step on the bit array s[1..288]; returns the output bit.
   function automatic bit model_step();
      bit a1, a2, a3, zz;
      a1 = s[66] ^ s[93];
      a2 = s[162] ^ s[177];
      a3 = s[243] ^ s[288];
      zz = a1 ^ a2 ^ a3;
      a1 = a1 ^ (s[91] & s[92]) ^ s[171];
      a2 = a2 ^ (s[175] & s[176]) ^ s[264];
      a3 = a3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 93; i > 1; i--) s[i] = s[i-1];
      s[1] = a3;
      for (int i = 177; i > 94; i--) s[i] = s[i-1];
      s[94] = a1;
      for (int i = 288; i > 178; i--) s[i] = s[i-1];
      s[178] = a2;
      return zz;
   endfunction

   task automatic model_run(input int nbytes);
      logic [7:0] b;
      b = '0;
      for (int i = 1; i <= 288; i++) s[i] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         for (int bb = 0; bb < 8; bb++) begin
            s[8*k+bb+1] = key_arr[k][bb];
            s[94+8*k+bb] = iv_arr[k][bb];
         end
      end
      s[286] = 1'b1;
      s[287] = 1'b1;
      s[288] = 1'b1;
      repeat (WARMUP) void'(model_step());
      exp_q.delete();
      for (int n = 0; n < nbytes; n++) begin
         for (int bb = 0; bb < 8; bb++) b[bb] = model_step();
         exp_q.push_back(b);
      end
   endtask

   task automatic random_seed();
`ifdef TRIVIUM_SEED_EXPAND_EN
      logic [7:0] r;
      r = 8'($urandom);
      for (int k = 0; k < 10; k++) begin
         key_arr[k] = r;
         iv_arr[k]  = r ^ 8'hA5;
      end
`else
      for (int k = 0; k < 10; k++) begin
         key_arr[k] = 8'($urandom);
         iv_arr[k]  = 8'($urandom);
      end
`endif
   endtask

   task automatic load_seed(input bit gaps);
      bit err_seen;
      err_seen = 1'b0;
`ifdef TRIVIUM_SEED_EXPAND_EN
      if (gaps) begin
         bus.seed_valid = 1'b0;
         tick();
      end
      bus.seed_valid = 1'b1;
      bus.seed_byte  = key_arr[0];
      tick();
      err_seen = bus.seed_err;
`else
      for (int k = 0; k < 20; k++) begin
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               bus.seed_valid = 1'b0;
               tick();
               err_seen |= bus.seed_err;
            end
         end
         bus.seed_valid = 1'b1;
         if (k < 10) bus.seed_byte = key_arr[k];
         else        bus.seed_byte = iv_arr[k-10];
         tick();
         err_seen |= bus.seed_err;
      end
`endif
      bus.seed_valid = 1'b0;
      check_val("load_no_seed_err", 32'(err_seen), 0);
      check_val("busy_after_load", 32'(bus.busy), 1);
   endtask

   // Count edges from the last seed byte to ks_valid; optionally poke seed_valid mid-warm-up.
   task automatic wait_first(input int inject_at);
      int cnt;
      cnt = 0;
      while (!bus.ks_valid && cnt < WARMUP + 100) begin
         bus.seed_valid = (cnt == inject_at);
         bus.seed_byte  = 8'h55;
         tick();
         cnt++;
         if (inject_at >= 0 && cnt == inject_at + 1) check_val("seed_err_pulse", 32'(bus.seed_err), 1);
         if (inject_at >= 0 && cnt == inject_at + 2) check_val("seed_err_single", 32'(bus.seed_err), 0);
      end
      bus.seed_valid = 1'b0;
      check_val("first_valid_latency", cnt, WARMUP + 8);
      check_val("seeded_at_valid", 32'(bus.seeded), 1);
   endtask

   task automatic collect(input int nbytes, input bit stall);
      got_q.delete();
      for (int i = 0; i < nbytes; i++) begin
         if (i > 0) begin
            int cnt;
            cnt = 0;
            while (!bus.ks_valid && cnt < 64) begin
               bus.ks_ready = 1'($urandom_range(0, 1));
               tick();
               cnt++;
            end
            check_val("next_valid_latency", cnt, 8);
         end
         got_q.push_back(bus.ks_byte);
         if (stall) begin
            logic [7:0] held;
            int bad;
            held = bus.ks_byte;
            bad  = 0;
            bus.ks_ready = 1'b0;
            repeat (50) begin
               tick();
               if (bus.ks_byte !== held || bus.ks_valid !== 1'b1) bad++;
            end
            check_val("hold_stable", bad, 0);
            check_val("busy_low_in_hold", 32'(bus.busy), 0);
         end
         bus.ks_ready = 1'b1;
         tick();
         bus.ks_ready = 1'b0;
         check_val("valid_drop_after_hs", 32'(bus.ks_valid), 0);
      end
   endtask

   task automatic run_seed(input bit gaps, input bit stall, input int inject_at, input string tag);
      model_run(4);
      load_seed(gaps);
      wait_first(inject_at);
      collect(4, stall);
      for (int i = 0; i < 4; i++)
         check_val($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_ks_valid"}, 32'(bus.ks_valid), 0);
      check_val({tag, "_busy"},     32'(bus.busy), 0);
      check_val({tag, "_seeded"},   32'(bus.seeded), 0);
      check_val({tag, "_seed_err"}, 32'(bus.seed_err), 0);
      check_val({tag, "_ks_byte"},  32'(bus.ks_byte), 0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cnt;
      bit  differs;
      bus.clear      = 1'b0;
      bus.seed_valid = 1'b0;
      bus.seed_byte  = 8'h00;
      bus.ks_ready   = 1'b0;
      rst_n = 1'b0;
      repeat (2) tick();
      check_idle("reset");
      rst_n = 1'b1;
      tick();

`ifdef TRIVIUM_SEED_EXPAND_EN
      for (int k = 0; k < 10; k++) begin
         key_arr[k] = 8'hBB;
         iv_arr[k]  = 8'h1E;
      end
      run_seed(1'b0, 1'b0, -1, "expand_bb");
      do_clear();
      random_seed();
      run_seed(1'b1, 1'b1, 200, "expand_rand");
`else
      for (int k = 0; k < 10; k++) begin
         key_arr[k] = 8'h00;
         iv_arr[k]  = 8'h00;
      end
      run_seed(1'b0, 1'b0, -1, "zero_seed");

      do_clear();
      for (int k = 0; k < 10; k++) begin
         key_arr[k] = 8'(k + 1);
         iv_arr[k]  = 8'(8'hF0 + k);
      end
      run_seed(1'b0, 1'b1, -1, "stall_seed");
      base_q = got_q;

      do_clear();
      run_seed(1'b1, 1'b0, -1, "reload");
      for (int i = 0; i < 4; i++) check_val("reload_same", 32'(got_q[i]), 32'(base_q[i]));

      key_arr[3][4] = ~key_arr[3][4];
      do_clear();
      run_seed(1'b0, 1'b0, -1, "flip");
      differs = 1'b0;
      for (int i = 0; i < 4; i++) if (got_q[i] !== base_q[i]) differs = 1'b1;
      check_val("flip_differs", 32'(differs), 1);

      do_clear();
      random_seed();
      run_seed(1'b0, 1'b0, 300, "warmup_poke");

      for (int r = 0; r < 3; r++) begin
         do_clear();
         random_seed();
         run_seed(1'b1, 1'b0, -1, "rand");
      end
`endif

      do_clear();
      random_seed();
      load_seed(1'b0);
      repeat (600) tick();
      do_clear();
      check_idle("clear_warmup");

      random_seed();
      run_seed(1'b0, 1'b0, -1, "after_clear");
      cnt = 0;
      while (!bus.ks_valid && cnt < 64) begin
         tick();
         cnt++;
      end
      check_val("hold_reached", 32'(bus.ks_valid), 1);
      rst_n = 1'b0;
      tick();
      check_idle("reset_hold");
      rst_n = 1'b1;
      tick();

      random_seed();
      run_seed(1'b0, 1'b0, -1, "after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
